// File: rtl/chipram_arbiter_if.sv
// Bus bundle for the chip RAM arbiter: video and CPU requester ports plus the RAM port.
// The arbiter takes the slave view; the environment driving it takes the master view.
interface chipram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;

  logic              cpu_req;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              starved;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_wr, cpu_addr, cpu_wdata, mem_rdata,
    output vid_gnt, vid_rvalid, vid_rdata, cpu_gnt, cpu_rvalid, cpu_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, starved
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_wr, cpu_addr, cpu_wdata, mem_rdata,
    input  vid_gnt, vid_rvalid, vid_rdata, cpu_gnt, cpu_rvalid, cpu_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, starved
  );
endinterface

// File: rtl/chipram_arbiter.sv
// Shares the single-port chip RAM between the video line fetcher (fixed priority)
// and the 6502 CPU, with a saturating starvation counter bounding CPU wait time.
module chipram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic             sys_clk,
  input  logic             sys_reset,
  chipram_arbiter_if.slave bus
);
  localparam logic [7:0] STARVE_MAX_C = 8'(STARVE_MAX);

  logic              vid_gnt_s;
  logic              cpu_gnt_s;
  logic              rd_xfer_s;
  logic [7:0]        starve_cnt_s;
  logic [7:0]        starve_cnt_r;
  logic              starved_r;

  logic              mem_en_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;

  // Bit k of each vector is tag stage k; stage RD_LAT lines up with mem_rdata.
  logic [RD_LAT:0]   tag_vld_r;
  logic [RD_LAT:0]   tag_cpu_r;

  logic              vid_rvalid_r;
  logic              cpu_rvalid_r;
  logic [DATA_W-1:0] vid_rdata_r;
  logic [DATA_W-1:0] cpu_rdata_r;

  // Grant: video first, CPU first once starved; nothing while reset is held.
  always_comb begin
    vid_gnt_s = 1'b0;
    cpu_gnt_s = 1'b0;
    if (!sys_reset) begin
      vid_gnt_s = 1'b0;
      cpu_gnt_s = 1'b0;
    end else if (bus.cpu_req && (!bus.vid_req || starved_r)) begin
      cpu_gnt_s = 1'b1;
    end else if (bus.vid_req) begin
      vid_gnt_s = 1'b1;
    end else begin
      vid_gnt_s = 1'b0;
      cpu_gnt_s = 1'b0;
    end
  end

  assign rd_xfer_s = vid_gnt_s | (cpu_gnt_s & ~bus.cpu_wr);

  // Next starvation count: counts lost cycles of a held CPU request, saturating.
  always_comb begin
    starve_cnt_s = starve_cnt_r;
    if (!bus.cpu_req || cpu_gnt_s) begin
      starve_cnt_s = 8'd0;
    end else if (starve_cnt_r < STARVE_MAX_C) begin
      starve_cnt_s = starve_cnt_r + 8'd1;
    end else begin
      starve_cnt_s = starve_cnt_r;
    end
  end

  // Starvation state register.
  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      starve_cnt_r <= 8'd0;
      starved_r    <= 1'b0;
    end else begin
      starve_cnt_r <= starve_cnt_s;
      starved_r    <= (starve_cnt_s == STARVE_MAX_C);
    end
  end

  // RAM issue register; video has no write data so mem_wdata keeps the last CPU value.
  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else if (vid_gnt_s) begin
      mem_en_r    <= 1'b1;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= bus.vid_addr;
    end else if (cpu_gnt_s) begin
      mem_en_r    <= 1'b1;
      mem_we_r    <= bus.cpu_wr;
      mem_addr_r  <= bus.cpu_addr;
      mem_wdata_r <= bus.cpu_wdata;
    end else begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
    end
  end

  // Owner tag pipeline; writes enter invalid so they never produce a return.
  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      tag_vld_r <= '0;
      tag_cpu_r <= '0;
    end else begin
      tag_vld_r <= {tag_vld_r[RD_LAT-1:0], rd_xfer_s};
      tag_cpu_r <= {tag_cpu_r[RD_LAT-1:0], cpu_gnt_s};
    end
  end

  // Return stage: capture mem_rdata against the last tag and steer it to its owner.
  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      vid_rvalid_r <= 1'b0;
      cpu_rvalid_r <= 1'b0;
      vid_rdata_r  <= '0;
      cpu_rdata_r  <= '0;
    end else begin
      vid_rvalid_r <= tag_vld_r[RD_LAT] & ~tag_cpu_r[RD_LAT];
      cpu_rvalid_r <= tag_vld_r[RD_LAT] & tag_cpu_r[RD_LAT];
      if (tag_vld_r[RD_LAT] && !tag_cpu_r[RD_LAT]) begin
        vid_rdata_r <= bus.mem_rdata;
      end else begin
        vid_rdata_r <= vid_rdata_r;
      end
      if (tag_vld_r[RD_LAT] && tag_cpu_r[RD_LAT]) begin
        cpu_rdata_r <= bus.mem_rdata;
      end else begin
        cpu_rdata_r <= cpu_rdata_r;
      end
    end
  end

  assign bus.vid_gnt    = vid_gnt_s;
  assign bus.cpu_gnt    = cpu_gnt_s;
  assign bus.mem_en     = mem_en_r;
  assign bus.mem_we     = mem_we_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign bus.vid_rvalid = vid_rvalid_r;
  assign bus.vid_rdata  = vid_rdata_r;
  assign bus.cpu_rvalid = cpu_rvalid_r;
  assign bus.cpu_rdata  = cpu_rdata_r;
  assign bus.starved    = starved_r;
endmodule

// File: tb/tb_chipram_arbiter.sv
// Randomized scoreboard bench for chipram_arbiter: a RAM model, a rule-level reference
// of grants/starvation/returns, and a negedge monitor comparing against it.
module tb_chipram_arbiter;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 8;
  localparam int RD_LAT     = 3;
  localparam int STARVE_MAX = 8;

  logic sys_clk   = 1'b0;
  logic sys_reset = 1'b1;
  always #5 sys_clk = ~sys_clk;

  chipram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  chipram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_reset(sys_reset),
    .bus      (bus)
  );

  function automatic logic [7:0] init_byte(int i);
    return 8'(i * 29 + 7);
  endfunction

  // RAM: write lands on the edge after mem_en, read data appears RD_LAT cycles after mem_en.
  logic [7:0] ram [256];
  logic [7:0] rd_pipe [RD_LAT];
  logic       loaded = 1'b0;
  always @(posedge sys_clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_byte(i);
      loaded <= 1'b1;
    end else if (bus.mem_en && bus.mem_we) begin
      ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
    rd_pipe[0] <= ram[bus.mem_addr[7:0]];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata = rd_pipe[RD_LAT-1];

  typedef struct {
    bit         is_cpu;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  ref_mem [256];
  int          m_cnt = 0;
  int          cyc = 0;
  logic        exp_en = 1'b0, exp_we = 1'b0;
  logic [15:0] exp_addr = 16'h0000;
  logic [7:0]  exp_wdata = 8'h00;
  logic [7:0]  last_vid = 8'h00, last_cpu = 8'h00;
  int          checks = 0, failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: applies the arbitration rules at each edge and queues expected returns.
  initial begin
    bit st, vg, cg;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    forever begin
      @(posedge sys_clk);
      cyc++;
      if (!sys_reset) begin
        m_cnt = 0; exp_en = 1'b0; exp_we = 1'b0; exp_addr = 16'h0000; exp_wdata = 8'h00;
      end else begin
        st = (m_cnt == STARVE_MAX);
        vg = bus.vid_req && !(bus.cpu_req && st);
        cg = bus.cpu_req && (!bus.vid_req || st);
        if (vg) begin
          q.push_back('{1'b0, ref_mem[bus.vid_addr[7:0]], cyc + RD_LAT + 1});
          exp_en = 1'b1; exp_we = 1'b0; exp_addr = bus.vid_addr;
        end else if (cg) begin
          exp_en = 1'b1; exp_we = bus.cpu_wr; exp_addr = bus.cpu_addr; exp_wdata = bus.cpu_wdata;
          if (bus.cpu_wr) ref_mem[bus.cpu_addr[7:0]] = bus.cpu_wdata;
          else q.push_back('{1'b1, ref_mem[bus.cpu_addr[7:0]], cyc + RD_LAT + 1});
        end else begin
          exp_en = 1'b0; exp_we = 1'b0;
        end
        if (bus.cpu_req && !cg) m_cnt = (m_cnt + 1 > STARVE_MAX) ? STARVE_MAX : m_cnt + 1;
        else m_cnt = 0;
      end
    end
  end

  // Monitor: compares grants, issue port and returns mid-cycle against the model.
  initial begin
    exp_t e;
    bit   st, vg, cg, rv_any;
    forever begin
      @(negedge sys_clk);
      rv_any = bus.vid_rvalid | bus.cpu_rvalid;
      if (!sys_reset) begin
        chk("rst_vid_gnt", bus.vid_gnt, 1'b0);
        chk("rst_cpu_gnt", bus.cpu_gnt, 1'b0);
        chk("rst_mem_en", bus.mem_en, 1'b0);
        chk("rst_rvalid", rv_any, 1'b0);
        chk("rst_starved", bus.starved, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 16'h0000);
        chk("rst_rdata", {bus.vid_rdata, bus.cpu_rdata}, 16'h0000);
        q.delete();
        last_vid = 8'h00;
        last_cpu = 8'h00;
      end else begin
        st = (m_cnt == STARVE_MAX);
        vg = bus.vid_req && !(bus.cpu_req && st);
        cg = bus.cpu_req && (!bus.vid_req || st);
        chk("vid_gnt", bus.vid_gnt, vg);
        chk("cpu_gnt", bus.cpu_gnt, cg);
        chk("starved", bus.starved, st);
        chk("mem_en", bus.mem_en, exp_en);
        chk("mem_we", bus.mem_we, exp_we);
        chk("mem_addr", bus.mem_addr, exp_addr);
        chk("mem_wdata", bus.mem_wdata, exp_wdata);
        chk("single_rvalid", bus.vid_rvalid & bus.cpu_rvalid, 1'b0);
        if (rv_any) begin
          if (q.size() == 0) begin
            chk("spurious_rvalid", rv_any, 1'b0);
          end else begin
            e = q.pop_front();
            chk("ret_owner_cpu", bus.cpu_rvalid, e.is_cpu);
            chk("ret_cycle", cyc, e.due);
            if (e.is_cpu) last_cpu = e.data;
            else last_vid = e.data;
          end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
          chk("missing_rvalid", rv_any, 1'b1);
          void'(q.pop_front());
        end
        chk("vid_rdata", bus.vid_rdata, last_vid);
        chk("cpu_rdata", bus.cpu_rdata, last_cpu);
      end
    end
  end

  // Requests are held until the edge that grants them; occasionally withdrawn.
  task automatic run(int n, int rate);
    bit vd, cd;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      vd = bus.vid_req & bus.vid_gnt;
      cd = bus.cpu_req & bus.cpu_gnt;
      @(posedge sys_clk);
      #1;
      if (bus.vid_req && !vd) begin
        if ($urandom_range(15) == 0) bus.vid_req = 1'b0;
      end else begin
        bus.vid_req  = ($urandom_range(99) < rate);
        bus.vid_addr = 16'($urandom_range(15));
      end
      if (bus.cpu_req && !cd) begin
        if ($urandom_range(15) == 0) bus.cpu_req = 1'b0;
      end else begin
        bus.cpu_req   = ($urandom_range(99) < rate);
        bus.cpu_wr    = 1'($urandom_range(1));
        bus.cpu_addr  = 16'($urandom_range(15));
        bus.cpu_wdata = 8'($urandom);
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge sys_clk);
    #1 sys_reset = 1'b0;
    @(posedge sys_clk);
    #1 sys_reset = 1'b1;
  endtask

  initial begin
    bus.vid_req = 1'b1; bus.vid_addr = 16'h0005;
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 16'h0003; bus.cpu_wdata = 8'h00;
    #1 sys_reset = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1 sys_reset = 1'b1;
    run(300, 100);
    for (int k = 0; k < 6; k++) begin
      run(250, 50);
      run(4, 100);
      pulse_reset();
    end
    run(400, 30);
    @(posedge sys_clk);
    #1;
    bus.vid_req = 1'b0;
    bus.cpu_req = 1'b0;
    repeat (RD_LAT + 4) @(posedge sys_clk);
    @(negedge sys_clk);
    #1;
    chk("drain_outstanding", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
